// File: rtl/watch_pkg.sv
// watch_pkg: shared constants for the watch time-of-day datapath.
//   - cursor_e : field-select encoding driven by the control unit
//   - *_W      : field register widths
//   - *_MAX    : last legal value of each field before it wraps to 0
package watch_pkg;

    typedef enum logic [1:0] {
        CUR_HOUR = 2'd0,
        CUR_MIN  = 2'd1,
        CUR_SEC  = 2'd2,
        CUR_MSEC = 2'd3
    } cursor_e;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MSEC_W = 7;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;

endpackage

// File: rtl/watch_tick_gen.sv
// watch_tick_gen: free-running clock divider producing a 1-clk tick.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset (count -> 0)
//   hold  - freeze the count and suppress the tick
//   clear - synchronous restart of the count at 0
//   tick  - high for one clk while the count sits at DIV-1 (wrap cycle)
module watch_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = !hold && (cnt == LAST);

endmodule

// File: rtl/watch_dp.sv
// watch_dp: time-of-day datapath (hour:min:sec:centisecond) for the watch
// edit path. Fields free-run from a divided tick and accept per-field
// inc/dec edits that wrap inside the field without carry/borrow.
// Ports:
//   clk, reset       - clock, asynchronous active-low reset
//   cursor           - field select (watch_pkg::cursor_e)
//   inc_pulse        - +1 on selected field
//   dec_pulse        - -1 on selected field (inc&dec together: no change)
//   reset_pulse      - reload INIT_* and restart the divider
//   edit_active      - edit level, used only with WATCH_DP_EDIT_PAUSE_EN
//   hour/min/sec/msec- registered time fields
//   day_wrap         - 1-clk pulse on 23:59:59.99 -> 00:00:00.00
// Optional build macro: WATCH_DP_EDIT_PAUSE_EN freezes time while
// edit_active is high.
module watch_dp
    import watch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int          INIT_HOUR = 12,
    parameter int          INIT_MIN  = 0,
    parameter int          INIT_SEC  = 0,
    parameter int          INIT_MSEC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cursor,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    input  logic              reset_pulse,
    input  logic              edit_active,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic [MSEC_W-1:0] msec,
    output logic              day_wrap
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    localparam logic [HOUR_W-1:0] INIT_H = HOUR_W'(INIT_HOUR);
    localparam logic [MIN_W-1:0]  INIT_M = MIN_W'(INIT_MIN);
    localparam logic [SEC_W-1:0]  INIT_S = SEC_W'(INIT_SEC);
    localparam logic [MSEC_W-1:0] INIT_C = MSEC_W'(INIT_MSEC);

    if (INIT_HOUR < 0 || INIT_HOUR > int'(HOUR_MAX)) begin : g_bad_init_hour
        $error("watch_dp: INIT_HOUR out of range");
    end
    if (INIT_MIN < 0 || INIT_MIN > int'(MIN_MAX)) begin : g_bad_init_min
        $error("watch_dp: INIT_MIN out of range");
    end
    if (INIT_SEC < 0 || INIT_SEC > int'(SEC_MAX)) begin : g_bad_init_sec
        $error("watch_dp: INIT_SEC out of range");
    end
    if (INIT_MSEC < 0 || INIT_MSEC > int'(MSEC_MAX)) begin : g_bad_init_msec
        $error("watch_dp: INIT_MSEC out of range");
    end

    logic pause;
`ifdef WATCH_DP_EDIT_PAUSE_EN
    assign pause = edit_active;
`else
    logic unused_edit_active;
    assign unused_edit_active = edit_active;
    assign pause = 1'b0;
`endif

    logic tick;
    logic tick_pend;

    watch_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .hold (pause),
        .clear(reset_pulse),
        .tick (tick)
    );

    logic edit_cycle;
    logic run_req;
    logic msec_wrap, sec_wrap, min_wrap, hour_wrap;

    assign edit_cycle = inc_pulse | dec_pulse;
    assign run_req    = !pause && (tick || tick_pend);

    assign msec_wrap = (msec == MSEC_MAX);
    assign sec_wrap  = (sec  == SEC_MAX);
    assign min_wrap  = (min  == MIN_MAX);
    assign hour_wrap = (hour == HOUR_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hour      <= INIT_H;
            min       <= INIT_M;
            sec       <= INIT_S;
            msec      <= INIT_C;
            day_wrap  <= 1'b0;
            tick_pend <= 1'b0;
        end else begin
            day_wrap <= 1'b0;
            if (reset_pulse) begin
                hour      <= INIT_H;
                min       <= INIT_M;
                sec       <= INIT_S;
                msec      <= INIT_C;
                tick_pend <= 1'b0;
            end else if (edit_cycle) begin
                // A tick landing in an edit cycle is parked; a second one is dropped.
                tick_pend <= (tick_pend || tick) && !pause;
                if (inc_pulse ^ dec_pulse) begin
                    unique case (cursor_e'(cursor))
                        CUR_HOUR: hour <= inc_pulse ? (hour_wrap ? '0 : hour + HOUR_W'(1))
                                                    : ((hour == '0) ? HOUR_MAX : hour - HOUR_W'(1));
                        CUR_MIN:  min  <= inc_pulse ? (min_wrap ? '0 : min + MIN_W'(1))
                                                    : ((min == '0) ? MIN_MAX : min - MIN_W'(1));
                        CUR_SEC:  sec  <= inc_pulse ? (sec_wrap ? '0 : sec + SEC_W'(1))
                                                    : ((sec == '0) ? SEC_MAX : sec - SEC_W'(1));
                        CUR_MSEC: msec <= inc_pulse ? (msec_wrap ? '0 : msec + MSEC_W'(1))
                                                    : ((msec == '0) ? MSEC_MAX : msec - MSEC_W'(1));
                    endcase
                end
            end else if (run_req) begin
                // Pending tick is consumed first; a fresh tick in the same
                // cycle takes its place in the pending slot.
                tick_pend <= tick_pend && tick;
                msec <= msec_wrap ? '0 : msec + MSEC_W'(1);
                if (msec_wrap) begin
                    sec <= sec_wrap ? '0 : sec + SEC_W'(1);
                end
                if (msec_wrap && sec_wrap) begin
                    min <= min_wrap ? '0 : min + MIN_W'(1);
                end
                if (msec_wrap && sec_wrap && min_wrap) begin
                    hour <= hour_wrap ? '0 : hour + HOUR_W'(1);
                end
                day_wrap <= msec_wrap && sec_wrap && min_wrap && hour_wrap;
            end else begin
                tick_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_watch_dp.sv
module tb_watch_dp;

    localparam int DIV      = 10;
    localparam int DAY      = 24 * 60 * 60 * 100;
    localparam int INIT_TOD = 12 * 360000;
`ifdef WATCH_DP_EDIT_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] cursor;
    logic       inc_pulse, dec_pulse, reset_pulse, edit_active;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] msec;
    logic       day_wrap;

    int checks = 0;
    int errors = 0;
    int dwcount = 0;
    bit cmp_en = 1'b0;

    watch_dp #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cursor     (cursor),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .reset_pulse(reset_pulse),
        .edit_active(edit_active),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .msec       (msec),
        .day_wrap   (day_wrap)
    );

    always #5 clk = ~clk;

    // Model: time of day as centiseconds since midnight, divider as a phase.
    int tod, phase, h, m, s, c, delta;
    bit pend, mwrap, tick, pz;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tod = INIT_TOD; phase = 0; pend = 0; mwrap = 0;
        end else begin
            pz    = PAUSE_EN && edit_active;
            tick  = !pz && (phase == DIV - 1);
            mwrap = 0;
            if (reset_pulse) begin
                tod = INIT_TOD; pend = 0; phase = 0;
            end else begin
                if (!pz) phase = (phase + 1) % DIV;
                if (inc_pulse || dec_pulse) begin
                    if (inc_pulse ^ dec_pulse) begin
                        delta = inc_pulse ? 1 : -1;
                        h = tod / 360000; m = (tod / 6000) % 60;
                        s = (tod / 100) % 60; c = tod % 100;
                        case (cursor)
                            2'd0: h = (h + delta + 24) % 24;
                            2'd1: m = (m + delta + 60) % 60;
                            2'd2: s = (s + delta + 60) % 60;
                            default: c = (c + delta + 100) % 100;
                        endcase
                        tod = ((h * 60 + m) * 60 + s) * 100 + c;
                    end
                    pend = (pend || tick) && !pz;
                end else if (!pz && (tick || pend)) begin
                    mwrap = (tod == DAY - 1);
                    tod   = (tod + 1) % DAY;
                    pend  = pend && tick;
                end else begin
                    pend = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (day_wrap === 1'b1) dwcount++;
        if (cmp_en) begin
            chk("model_hour", int'(hour), tod / 360000);
            chk("model_min",  int'(min),  (tod / 6000) % 60);
            chk("model_sec",  int'(sec),  (tod / 100) % 60);
            chk("model_msec", int'(msec), tod % 100);
            chk("model_day_wrap", int'(day_wrap), int'(mwrap));
        end
    end

    task automatic expect_time(input string nm, input int eh, input int em, input int es, input int ec);
        chk({nm, "_hour"}, int'(hour), eh);
        chk({nm, "_min"},  int'(min),  em);
        chk({nm, "_sec"},  int'(sec),  es);
        chk({nm, "_msec"}, int'(msec), ec);
    endtask

    task automatic drive(input bit rp, input bit inc, input bit dec, input logic [1:0] cur);
        reset_pulse = rp; inc_pulse = inc; dec_pulse = dec; cursor = cur;
        @(negedge clk);
        reset_pulse = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, cursor);
    endtask

    initial begin
        reset = 1'b0; cursor = 2'd0; inc_pulse = 1'b0; dec_pulse = 1'b0;
        reset_pulse = 1'b0; edit_active = 1'b0;
        repeat (3) @(negedge clk);
        expect_time("reset", 12, 0, 0, 0);
        chk("reset_day_wrap", int'(day_wrap), 0);
        reset = 1'b1;
        cmp_en = 1'b1;

        // 100 ticks from release
        idle(1000);
        expect_time("run100", 12, 0, 1, 0);
        chk("run100_no_day_wrap", dwcount, 0);

        // Preload 23:59:59.99 with edits, one tick wraps the day
        drive(1, 0, 0, 2'd0);
        repeat (13) drive(0, 0, 1, 2'd0);
        expect_time("hour_dec13", 23, 0, 0, 0);
        drive(0, 0, 1, 2'd1);
        drive(0, 0, 1, 2'd2);
        idle(1);
        drive(0, 0, 1, 2'd3);
        drive(0, 0, 1, 2'd3);
        idle(1);
        expect_time("preload_max", 23, 59, 59, 99);
        idle(1);
        expect_time("day_rollover", 0, 0, 0, 0);
        chk("day_wrap_high", int'(day_wrap), 1);
        idle(1);
        chk("day_wrap_low", int'(day_wrap), 0);
        chk("day_wrap_count", dwcount, 1);

        // In-field wrap, no carry/borrow
        drive(0, 0, 1, 2'd0);
        drive(0, 1, 0, 2'd0);
        expect_time("hour_inc_wrap", 0, 0, 0, 0);
        drive(0, 0, 1, 2'd1);
        expect_time("min_dec_wrap", 0, 59, 0, 0);

        // Edit on the tick edge parks the tick
        drive(1, 0, 0, 2'd3);
        idle(59);
        expect_time("pre_tick", 12, 0, 0, 5);
        drive(0, 1, 0, 2'd3);
        expect_time("inc_on_tick", 12, 0, 0, 6);
        idle(1);
        expect_time("pend_apply", 12, 0, 0, 7);
        drive(0, 1, 1, 2'd3);
        expect_time("inc_dec_same", 12, 0, 0, 7);

        // reset_pulse beats inc, divider restarts
        drive(1, 0, 0, 2'd0);
        repeat (9)  drive(0, 0, 1, 2'd0);
        repeat (7)  drive(0, 1, 0, 2'd1);
        repeat (9)  drive(0, 1, 0, 2'd2);
        repeat (11) drive(0, 1, 0, 2'd3);
        expect_time("preload_030709", 3, 7, 9, 11);
        drive(1, 1, 0, 2'd3);
        expect_time("rp_over_inc", 12, 0, 0, 0);
        idle(9);
        expect_time("div_restart_pre", 12, 0, 0, 0);
        idle(1);
        expect_time("div_restart_tick", 12, 0, 0, 1);

        // edit_active level for 50 clk
        drive(1, 0, 0, 2'd3);
        edit_active = 1'b1;
        idle(50);
        expect_time("edit_active_50", 12, 0, 0, PAUSE_EN ? 0 : 5);
        edit_active = 1'b0;

        // Async reset mid-divide
        drive(0, 0, 1, 2'd0);
        idle(3);
        #2 reset = 1'b0;
        #1 expect_time("async_reset", 12, 0, 0, 0);
        chk("async_reset_day_wrap", int'(day_wrap), 0);
        @(negedge clk);
        reset = 1'b1;
        idle(10);
        expect_time("post_reset_tick", 12, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
